// File: rtl/spi_raw_reg_ctrl.sv
// Command sequencer between a byte-level SPI slave core and a register bus.
// Optional read timeout and sticky err_timeout port: define SPI_RAW_REG_CTRL_TIMEOUT_EN.
module spi_raw_reg_ctrl #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_INC   = 1,
  parameter int TIMEOUT    = 64,
  localparam int DATA_WIDTH = 8 * DATA_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_active,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic [15:0]           reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_rvalid,
  output logic                  busy
`ifdef SPI_RAW_REG_CTRL_TIMEOUT_EN
  ,
  output logic                  err_timeout
`endif
);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR_HI, S_ADDR_LO, S_DUMMY, S_WDATA, S_RDATA, S_DISCARD
  } state_t;

  localparam logic [7:0]  CMD_WR    = 8'h00;
  localparam logic [7:0]  CMD_RD    = 8'h80;
  localparam logic [3:0]  LAST_BYTE = 4'(DATA_BYTES - 1);
  localparam logic [15:0] INC       = 16'(ADDR_INC);

  state_t                state, state_nxt;
  logic                  is_read;
  logic [3:0]            byte_cnt;
  logic                  rd_pending;
  logic                  rd_stale;   // outstanding read belongs to an ended frame
  logic                  rd_defer;   // read wanted but an earlier one is still outstanding
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] rd_buf;     // prefetched next word, waits for the word boundary

  logic                  frame_end, byte_in, cmd_ok, word_last;
  logic                  rd_req, rd_issue, rd_done, rd_hit;
  logic [DATA_WIDTH-1:0] rd_word, rd_src, rd_shift_nxt;

  // Level-sensitive: the first low cycle after a frame ends it and suppresses any byte in it.
  assign frame_end    = !frame_active;
  assign byte_in      = rx_valid && frame_active;
  assign cmd_ok       = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign word_last    = (byte_cnt == LAST_BYTE);
  assign busy         = (state != S_CMD);
  assign rd_req       = byte_in && (((state == S_ADDR_LO) && is_read) ||
                                    ((state == S_RDATA) && (byte_cnt == 4'd0)));
  assign rd_issue     = frame_active && (rd_req || rd_defer) && !rd_pending;
  assign rd_shift_nxt = rd_shift << 8;
  assign rd_src       = rd_hit ? rd_word : rd_buf;

`ifdef SPI_RAW_REG_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_fire;

  assign tmo_fire = rd_pending && !reg_rvalid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign rd_done  = (reg_rvalid || tmo_fire) && rd_pending;
  assign rd_word  = reg_rvalid ? reg_rdata : {DATA_BYTES{8'hEE}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (rd_issue)        tmo_cnt <= '0;
      else if (rd_pending) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_fire)                                   err_timeout <= 1'b1;
      else if (byte_in && (state == S_CMD) && cmd_ok) err_timeout <= 1'b0;
    end
  end
`else
  assign rd_done = reg_rvalid && rd_pending;
  assign rd_word = reg_rdata;
`endif

  assign rd_hit = rd_done && !rd_stale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CMD;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    if (frame_end) begin
      state_nxt = S_CMD;
    end else if (rx_valid) begin
      unique case (state)
        S_CMD:     state_nxt = cmd_ok ? S_ADDR_HI : S_DISCARD;
        S_ADDR_HI: state_nxt = S_ADDR_LO;
        S_ADDR_LO: state_nxt = is_read ? S_DUMMY : S_WDATA;
        S_DUMMY:   state_nxt = S_RDATA;
        default:   state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data    <= 8'h00;
      reg_addr   <= 16'h0000;
      reg_wdata  <= '0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      is_read    <= 1'b0;
      byte_cnt   <= 4'd0;
      rd_pending <= 1'b0;
      rd_stale   <= 1'b0;
      rd_defer   <= 1'b0;
      rd_shift   <= '0;
      rd_buf     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (reg_wr) reg_addr <= reg_addr + INC;

      if (rd_done) begin
        rd_pending <= 1'b0;
        rd_stale   <= 1'b0;
      end else if (frame_end && rd_pending) begin
        rd_stale <= 1'b1;
      end

      if (frame_end) begin
        byte_cnt <= 4'd0;
        tx_data  <= 8'h00;
        rd_defer <= 1'b0;
      end else begin
        if (rd_issue) begin
          reg_rd     <= 1'b1;
          rd_pending <= 1'b1;
          rd_defer   <= 1'b0;
        end else if (rd_req) begin
          rd_defer <= 1'b1;
        end

        if (rd_hit && (state == S_DUMMY)) begin
          rd_shift <= rd_word;
          tx_data  <= rd_word[DATA_WIDTH-1 -: 8];
        end
        if (rd_hit && (state == S_RDATA)) rd_buf <= rd_word;

        if (rx_valid) begin
          case (state)
            S_CMD: begin
              is_read <= (rx_data == CMD_RD);
              if (!cmd_ok) tx_data <= 8'hFF;
            end
            S_ADDR_HI: reg_addr[15:8] <= rx_data;
            S_ADDR_LO: begin
              reg_addr[7:0] <= rx_data;
              byte_cnt      <= 4'd0;
            end
            S_WDATA: begin
              reg_wdata <= (reg_wdata << 8) | DATA_WIDTH'(rx_data);
              if (word_last) begin
                byte_cnt <= 4'd0;
                reg_wr   <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
              end
            end
            S_RDATA: begin
              if (byte_cnt == 4'd0) reg_addr <= reg_addr + INC;
              if (word_last) begin
                rd_shift <= rd_src;
                tx_data  <= rd_src[DATA_WIDTH-1 -: 8];
                byte_cnt <= 4'd0;
              end else begin
                rd_shift <= rd_shift_nxt;
                tx_data  <= rd_shift_nxt[DATA_WIDTH-1 -: 8];
                byte_cnt <= byte_cnt + 4'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_raw_reg_ctrl.sv
// Self-checking bench for spi_raw_reg_ctrl: directed frames plus randomized frames
// checked against a transaction-level model of writes, reads and transmit bytes.
module tb_spi_raw_reg_ctrl;

  localparam int DB       = 4;
  localparam int ADDR_INC = 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    int          due;
    logic [15:0] addr;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_active;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        busy;
`ifdef SPI_RAW_REG_CTRL_TIMEOUT_EN
  logic        err_timeout;
`endif

  spi_raw_reg_ctrl #(.DATA_BYTES(DB), .ADDR_INC(ADDR_INC), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_active (frame_active),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_wr       (reg_wr),
    .reg_rd       (reg_rd),
    .reg_rdata    (reg_rdata),
    .reg_rvalid   (reg_rvalid),
    .busy         (busy)
`ifdef SPI_RAW_REG_CTRL_TIMEOUT_EN
    ,
    .err_timeout  (err_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int byte_time = 16;
  int bus_lat = -1;
  bit bus_mute = 1'b0;

  wr_t         exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [7:0]  frame_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  pay_q[$];
  logic [31:0] mem_ovr[logic [15:0]];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a ^ 16'h5A3C, ~a};
  endfunction

  // Register bus: answers every reg_rd once, after a latency, from the memory model.
  initial begin
    rsp_t rsp_q[$];
    rsp_t r;
    int   cyc;
    int   last_due;
    reg_rvalid = 1'b0;
    reg_rdata  = '0;
    cyc        = 0;
    last_due   = 0;
    forever begin
      @(negedge clk);
      cyc++;
      reg_rvalid = 1'b0;
      if (!rst_n) begin
        rsp_q.delete();
      end else begin
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          r = rsp_q.pop_front();
          if (!bus_mute) begin
            reg_rvalid = 1'b1;
            reg_rdata  = mem_rd(r.addr);
          end
        end
        if (reg_rd) begin
          r.due  = cyc + ((bus_lat < 0) ? int'($urandom_range(2, 8)) : bus_lat);
          if (r.due <= last_due) r.due = last_due + 1;
          last_due = r.due;
          r.addr = reg_addr;
          rsp_q.push_back(r);
        end
      end
    end
  end

  // Compare process: every register strobe is matched against the model's queues.
  always @(negedge clk) begin
    wr_t         ew;
    logic [15:0] er;
    if (rst_n) begin
      if (reg_wr || reg_rd) check("wr_rd_exclusive", {63'd0, reg_wr & reg_rd}, 64'd0);
      if (reg_wr) begin
        if (exp_wr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h, expected no write", reg_addr, reg_wdata);
        end else begin
          ew = exp_wr_q.pop_front();
          check("wr_addr", 64'(reg_addr), 64'(ew.addr));
          check("wr_data", 64'(reg_wdata), 64'(ew.data));
        end
      end
      if (reg_rd) begin
        if (exp_rd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rd: got addr 0x%0h, expected no read", reg_addr);
        end else begin
          er = exp_rd_q.pop_front();
          check("rd_addr", 64'(reg_addr), 64'(er));
        end
      end
    end
  end

  // One SPI byte: tx_data is sampled at the load point, rx_valid pulses at the byte end.
  task automatic byte_slot(input logic [7:0] b, input logic [7:0] etx, input string nm);
    repeat (2) @(posedge clk);
    #1 check({nm, "_tx"}, 64'(tx_data), 64'(etx));
    repeat (byte_time - 3) @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string nm);
    frame_active = 1'b1;
    foreach (frame_q[i]) byte_slot(frame_q[i], tx_q[i], nm);
    repeat (4) @(posedge clk);
    #1 if (frame_q.size() > 0) check({nm, "_busy_in_frame"}, 64'(busy), 64'd1);
    frame_active = 1'b0;
    @(posedge clk);
    #1 check({nm, "_busy_after_end"}, 64'(busy), 64'd0);
    check({nm, "_tx_after_end"}, 64'(tx_data), 64'd0);
    repeat (12) @(posedge clk);
    #1 check({nm, "_writes_left"}, 64'(exp_wr_q.size()), 64'd0);
    check({nm, "_reads_left"}, 64'(exp_rd_q.size()), 64'd0);
    exp_wr_q.delete();
    exp_rd_q.delete();
    frame_q.delete();
    tx_q.delete();
  endtask

  // Model: only complete words are written, at consecutive (wrapping) addresses.
  task automatic build_write(input logic [15:0] a);
    logic [31:0] w;
    frame_q = '{8'h00, a[15:8], a[7:0]};
    tx_q    = '{8'h00, 8'h00, 8'h00};
    foreach (pay_q[k]) begin
      frame_q.push_back(pay_q[k]);
      tx_q.push_back(8'h00);
    end
    for (int i = 0; i < pay_q.size() / DB; i++) begin
      w = {pay_q[4*i], pay_q[4*i+1], pay_q[4*i+2], pay_q[4*i+3]};
      exp_wr_q.push_back('{addr: a + 16'(i * ADDR_INC), data: w});
    end
  endtask

  // Model: first read at the frame address, one prefetch per started word; data MSB first.
  task automatic build_read(input logic [15:0] a);
    logic [31:0] w;
    frame_q = '{8'h80, a[15:8], a[7:0], 8'($urandom)};
    tx_q    = '{8'h00, 8'h00, 8'h00, 8'h00};
    exp_rd_q.push_back(a);
    foreach (pay_q[k]) begin
      frame_q.push_back(pay_q[k]);
      w = mem_rd(a + 16'((k / DB) * ADDR_INC));
      tx_q.push_back(w[31 - 8 * (k % DB) -: 8]);
      if (k % DB == 0) exp_rd_q.push_back(a + 16'((k / DB + 1) * ADDR_INC));
    end
  endtask

  task automatic build_illegal();
    logic [7:0] c;
    do c = 8'($urandom); while (c == 8'h00 || c == 8'h80);
    frame_q = '{c};
    tx_q    = '{8'h00};
    foreach (pay_q[k]) begin
      frame_q.push_back(pay_q[k]);
      tx_q.push_back(8'hFF);
    end
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_tx"},    64'(tx_data),   64'd0);
    check({nm, "_addr"},  64'(reg_addr),  64'd0);
    check({nm, "_wdata"}, 64'(reg_wdata), 64'd0);
    check({nm, "_wr"},    64'(reg_wr),    64'd0);
    check({nm, "_rd"},    64'(reg_rd),    64'd0);
    check({nm, "_busy"},  64'(busy),      64'd0);
  endtask

  initial begin
    int          kind;
    int          n;
    logic [15:0] a;

    rst_n        = 1'b0;
    frame_active = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
`ifdef SPI_RAW_REG_CTRL_TIMEOUT_EN
    check("reset_err_timeout", 64'(err_timeout), 64'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single write
    frame_q = '{8'h00, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tx_q    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_wr_q.push_back('{addr: 16'h1234, data: 32'hDEADBEEF});
    run_frame("single_write");

    // Burst read, fixed 3-cycle latency
    bus_lat = 3;
    mem_ovr[16'h0010] = 32'h11223344;
    mem_ovr[16'h0011] = 32'h55667788;
    frame_q = '{8'h80, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tx_q    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_rd_q = '{16'h0010, 16'h0011, 16'h0012};
    run_frame("burst_read");
    bus_lat = -1;

    // Illegal command, then a normal write
    frame_q = '{8'h5A, 8'h01, 8'h02, 8'h03};
    tx_q    = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
    run_frame("illegal");
    frame_q = '{8'h00, 8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    tx_q    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_wr_q.push_back('{addr: 16'h0001, data: 32'hA1B2C3D4});
    run_frame("after_illegal");

    // Aborted partial write word
    frame_q = '{8'h00, 8'h00, 8'h20, 8'hAA, 8'hBB};
    tx_q    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("aborted_write");

    // Address wrap
    frame_q = '{8'h00, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    tx_q    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_wr_q.push_back('{addr: 16'hFFFF, data: 32'h01020304});
    exp_wr_q.push_back('{addr: 16'h0000, data: 32'h05060708});
    run_frame("wrap");

    // Reset in the middle of a read burst
    bus_lat = 3;
    mem_ovr[16'h0040] = 32'h5A7CFFBF;
    frame_q = '{8'h80, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
    tx_q    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h7C};
    exp_rd_q = '{16'h0040, 16'h0041};
    frame_active = 1'b1;
    foreach (frame_q[i]) byte_slot(frame_q[i], tx_q[i], "mid_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    check("mid_reset_reads_left", 64'(exp_rd_q.size()), 64'd0);
    frame_active = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_rd_q.delete();
    frame_q.delete();
    tx_q.delete();
    repeat (2) @(posedge clk);
    #1;
    frame_q = '{8'h00, 8'h00, 8'h50, 8'h10, 8'h20, 8'h30, 8'h40};
    tx_q    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_wr_q.push_back('{addr: 16'h0050, data: 32'h10203040});
    run_frame("after_reset");
    bus_lat = -1;

`ifdef SPI_RAW_REG_CTRL_TIMEOUT_EN
    // Withheld read data: bytes time out to EE and the error sticks until the next command
    byte_time = 80;
    bus_mute  = 1'b1;
    pay_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    build_read(16'h0300);
    for (int k = 4; k < 8; k++) tx_q[k] = 8'hEE;
    run_frame("timeout");
    check("timeout_err_set", 64'(err_timeout), 64'd1);
    bus_mute  = 1'b0;
    byte_time = 16;
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    build_write(16'h0400);
    run_frame("timeout_clear");
    check("timeout_err_cleared", 64'(err_timeout), 64'd0);
`endif

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      n    = $urandom_range(0, 10);
      if ($urandom_range(0, 3) == 0) a = 16'hFFFF - 16'($urandom_range(0, 2));
      else                           a = 16'($urandom);
      pay_q.delete();
      for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom));
      if (kind < 5)      build_write(a);
      else if (kind < 9) build_read(a);
      else               build_illegal();
      run_frame("random");
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
